// File: rtl/ihex_loader.sv
// ----------------------------------------------------------------------------
// ihex_loader
// Streaming Intel HEX record parser. Consumes ASCII characters from the UART
// RX FIFO, checks each record's checksum, and turns accepted type-00 records
// into byte-granular write beats for the boot RAM. It also captures the
// type-04 upper address, the type-05 entry point and the type-01 EOF.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous, active-low reset
//   rx_data_i      ASCII character from the RX FIFO
//   rx_valid_i     rx_data_i valid
//   rx_ready_o     character accepted when rx_valid_i && rx_ready_o
//   wr_addr_o      word-aligned write address
//   wr_data_o      data byte replicated on all four lanes
//   wr_strb_o      one-hot byte strobe selected by byte address [1:0]
//   wr_valid_o     write beat valid
//   wr_ready_i     write beat accepted
//   entry_o        start linear address from a type-05 record
//   entry_valid_o  entry_o loaded (sticky)
//   done_o         EOF record accepted (sticky)
//   err_o          a record was rejected (sticky)
//   err_cnt_o      rejected-record count, saturating at 255
// ----------------------------------------------------------------------------
module ihex_loader #(
    parameter int MAX_LEN = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic [31:0] entry_o,
    output logic        entry_valid_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    // Types 04 and 05 read up to four buffered bytes, so the buffer never
    // shrinks below four entries even for a tiny MAX_LEN.
    localparam int BUF_D = (MAX_LEN < 4) ? 4 : MAX_LEN;
    localparam int IDX_W = $clog2(BUF_D);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_TYPE   = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_CSUM   = 3'd5;
    localparam logic [2:0] S_COMMIT = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [7:0] CH_COLON = 8'h3A;

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters A-F / a-f carry value 1..6 in their low nibble.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c <= 8'h39) begin
            return c[3:0];
        end else begin
            return c[3:0] + 4'd9;
        end
    endfunction

    logic [2:0]  state_r;
    logic        nib_r;        // high nibble already captured
    logic [3:0]  hi_nib_r;
    logic [7:0]  sum_r;
    logic [7:0]  len_r;
    logic [15:0] off_r;
    logic [7:0]  type_r;
    logic [7:0]  cnt_r;
    logic [7:0]  beat_r;
    logic [15:0] ext_hi_r;
    logic [7:0]  data_buf_r [BUF_D];
    logic        rx_ready_r;
    logic [31:0] wr_addr_r;
    logic [31:0] wr_data_r;
    logic [3:0]  wr_strb_r;
    logic        wr_valid_r;
    logic [31:0] entry_r;
    logic        entry_valid_r;
    logic        done_r;
    logic        err_r;
    logic [7:0]  err_cnt_r;

    logic        acc_s;
    logic        hex_s;
    logic        colon_s;
    logic [7:0]  byte_s;
    logic [7:0]  sum_nxt_s;
    logic        type_ok_s;
    logic        rec_ok_s;
    logic        in_rec_s;
    logic        rej_s;
    logic [7:0]  load_idx_s;
    logic [31:0] baddr_s;
    logic [7:0]  bdata_s;

    // Character decode, record validation and next write-beat formation.
    always_comb begin
        acc_s     = rx_valid_i && rx_ready_r;
        hex_s     = is_hex(rx_data_i);
        colon_s   = (rx_data_i == CH_COLON);
        byte_s    = {hi_nib_r, hex_val(rx_data_i)};
        sum_nxt_s = sum_r + byte_s;
        case (type_r)
            8'h00, 8'h02, 8'h03: type_ok_s = 1'b1;
            8'h01:               type_ok_s = (len_r == 8'd0);
            8'h04:               type_ok_s = (len_r == 8'd2);
            8'h05:               type_ok_s = (len_r == 8'd4);
            default:             type_ok_s = 1'b0;
        endcase
        rec_ok_s = (sum_nxt_s == 8'h00) && type_ok_s;
        in_rec_s = (state_r == S_LEN) || (state_r == S_ADDR) || (state_r == S_TYPE) ||
                   (state_r == S_DATA) || (state_r == S_CSUM);
        if (acc_s && in_rec_s) begin
            rej_s = colon_s || !hex_s ||
                    (nib_r && (((state_r == S_LEN) && (byte_s > MAX_LEN_B)) ||
                               ((state_r == S_CSUM) && !rec_ok_s)));
        end else begin
            rej_s = 1'b0;
        end
        // Beat 0 is loaded while CSUM is accepted, later beats during COMMIT.
        if (state_r == S_COMMIT) begin
            load_idx_s = beat_r + 8'd1;
        end else begin
            load_idx_s = 8'd0;
        end
        baddr_s = {ext_hi_r, off_r + {8'h00, load_idx_s}};
        bdata_s = data_buf_r[load_idx_s[IDX_W-1:0]];
    end

    // Error flag and saturating reject counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else if (rej_s) begin
            err_r <= 1'b1;
            if (err_cnt_r != 8'hFF) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    // Record parser FSM, data buffer, captured addresses and write beats.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r       <= S_IDLE;
            nib_r         <= 1'b0;
            hi_nib_r      <= 4'h0;
            sum_r         <= 8'h00;
            len_r         <= 8'h00;
            off_r         <= 16'h0000;
            type_r        <= 8'h00;
            cnt_r         <= 8'h00;
            beat_r        <= 8'h00;
            ext_hi_r      <= 16'h0000;
            for (int i = 0; i < BUF_D; i++) begin
                data_buf_r[i] <= 8'h00;
            end
            rx_ready_r    <= 1'b0;
            wr_addr_r     <= 32'h0;
            wr_data_r     <= 32'h0;
            wr_strb_r     <= 4'h0;
            wr_valid_r    <= 1'b0;
            entry_r       <= 32'h0;
            entry_valid_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            rx_ready_r <= (state_r != S_COMMIT);
            case (state_r)
                S_IDLE: begin
                    if (acc_s && colon_s) begin
                        state_r <= S_LEN;
                        sum_r   <= 8'h00;
                        nib_r   <= 1'b0;
                    end
                end
                S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM: begin
                    if (acc_s) begin
                        if (colon_s) begin
                            state_r <= S_LEN;
                            sum_r   <= 8'h00;
                            nib_r   <= 1'b0;
                        end else if (!hex_s) begin
                            state_r <= S_IDLE;
                            nib_r   <= 1'b0;
                        end else if (!nib_r) begin
                            hi_nib_r <= hex_val(rx_data_i);
                            nib_r    <= 1'b1;
                        end else begin
                            nib_r <= 1'b0;
                            sum_r <= sum_nxt_s;
                            case (state_r)
                                S_LEN: begin
                                    len_r   <= byte_s;
                                    cnt_r   <= 8'd0;
                                    state_r <= (byte_s > MAX_LEN_B) ? S_IDLE : S_ADDR;
                                end
                                S_ADDR: begin
                                    if (cnt_r == 8'd0) begin
                                        off_r[15:8] <= byte_s;
                                        cnt_r       <= 8'd1;
                                    end else begin
                                        off_r[7:0] <= byte_s;
                                        state_r    <= S_TYPE;
                                    end
                                end
                                S_TYPE: begin
                                    type_r  <= byte_s;
                                    cnt_r   <= 8'd0;
                                    state_r <= (len_r == 8'd0) ? S_CSUM : S_DATA;
                                end
                                S_DATA: begin
                                    data_buf_r[cnt_r[IDX_W-1:0]] <= byte_s;
                                    cnt_r <= cnt_r + 8'd1;
                                    if (cnt_r == len_r - 8'd1) begin
                                        state_r <= S_CSUM;
                                    end
                                end
                                S_CSUM: begin
                                    state_r <= S_IDLE;
                                    if (rec_ok_s) begin
                                        case (type_r)
                                            8'h00: begin
                                                if (len_r != 8'd0) begin
                                                    state_r    <= S_COMMIT;
                                                    rx_ready_r <= 1'b0;
                                                    beat_r     <= 8'd0;
                                                    wr_valid_r <= 1'b1;
                                                    wr_addr_r  <= {baddr_s[31:2], 2'b00};
                                                    wr_strb_r  <= 4'b0001 << baddr_s[1:0];
                                                    wr_data_r  <= {4{bdata_s}};
                                                end
                                            end
                                            8'h01: begin
                                                state_r <= S_DONE;
                                                done_r  <= 1'b1;
                                            end
                                            8'h04: begin
                                                ext_hi_r <= {data_buf_r[0], data_buf_r[1]};
                                            end
                                            8'h05: begin
                                                entry_r <= {data_buf_r[0], data_buf_r[1],
                                                            data_buf_r[2], data_buf_r[3]};
                                                entry_valid_r <= 1'b1;
                                            end
                                            default: begin
                                                state_r <= S_IDLE;
                                            end
                                        endcase
                                    end
                                end
                                default: begin
                                    state_r <= S_IDLE;
                                end
                            endcase
                        end
                    end
                end
                S_COMMIT: begin
                    if (wr_valid_r && wr_ready_i) begin
                        if (beat_r == len_r - 8'd1) begin
                            wr_valid_r <= 1'b0;
                            state_r    <= S_IDLE;
                            rx_ready_r <= 1'b1;
                        end else begin
                            beat_r    <= beat_r + 8'd1;
                            wr_addr_r <= {baddr_s[31:2], 2'b00};
                            wr_strb_r <= 4'b0001 << baddr_s[1:0];
                            wr_data_r <= {4{bdata_s}};
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_DONE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready_o    = rx_ready_r;
    assign wr_addr_o     = wr_addr_r;
    assign wr_data_o     = wr_data_r;
    assign wr_strb_o     = wr_strb_r;
    assign wr_valid_o    = wr_valid_r;
    assign entry_o       = entry_r;
    assign entry_valid_o = entry_valid_r;
    assign done_o        = done_r;
    assign err_o         = err_r;
    assign err_cnt_o     = err_cnt_r;

endmodule

// File: tb/tb_ihex_loader.sv
// Directed bench for ihex_loader. Instance u_a uses MAX_LEN=16, instance u_b
// uses MAX_LEN=8 for the oversize-length recovery sequence.
module tb_ihex_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sel;
    logic        wr_ready;

    logic        rdy_a, rdy_b, wv_a, wv_b, ev_a, ev_b, dn_a, dn_b, er_a, er_b;
    logic [31:0] wa_a, wa_b, wd_a, wd_b, en_a, en_b;
    logic [3:0]  ws_a, ws_b;
    logic [7:0]  ec_a, ec_b;
    logic        rv_a, rv_b, rdy_m;

    logic [67:0] q_a[$];
    logic [67:0] q_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    assign rv_a  = rx_valid && !sel;
    assign rv_b  = rx_valid && sel;
    assign rdy_m = sel ? rdy_b : rdy_a;

    always #5 clk = ~clk;

    ihex_loader #(.MAX_LEN(16)) u_a (
        .clk_i(clk), .rst_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rv_a),
        .rx_ready_o(rdy_a), .wr_addr_o(wa_a), .wr_data_o(wd_a), .wr_strb_o(ws_a),
        .wr_valid_o(wv_a), .wr_ready_i(wr_ready), .entry_o(en_a),
        .entry_valid_o(ev_a), .done_o(dn_a), .err_o(er_a), .err_cnt_o(ec_a));

    ihex_loader #(.MAX_LEN(8)) u_b (
        .clk_i(clk), .rst_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rv_b),
        .rx_ready_o(rdy_b), .wr_addr_o(wa_b), .wr_data_o(wd_b), .wr_strb_o(ws_b),
        .wr_valid_o(wv_b), .wr_ready_i(wr_ready), .entry_o(en_b),
        .entry_valid_o(ev_b), .done_o(dn_b), .err_o(er_b), .err_cnt_o(ec_b));

    // Record every accepted write beat of each instance.
    always @(negedge clk) begin
        if (wv_a && wr_ready) q_a.push_back({wa_a, wd_a, ws_a});
        if (wv_b && wr_ready) q_b.push_back({wa_b, wd_b, ws_b});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        rx_data  = c;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_m) check("rx_ready_timeout", {31'd0, rdy_m}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, rdy_m}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pop_beat(input string tag, input logic [31:0] ea,
                            input logic [31:0] ed, input logic [3:0] es);
        logic [67:0] b;
        int sz;
        sz = sel ? q_b.size() : q_a.size();
        check({tag, "_present"}, {31'd0, (sz > 0)}, 32'd1);
        if (sz > 0) begin
            b = sel ? q_b.pop_front() : q_a.pop_front();
            check({tag, "_addr"}, b[67:36], ea);
            check({tag, "_data"}, b[35:4], ed);
            check({tag, "_strb"}, {28'd0, b[3:0]}, {28'd0, es});
        end
    endtask

    initial begin
        logic [7:0] rec [16];
        rec = '{8'h13, 8'h01, 8'h01, 8'hFF, 8'h23, 8'h24, 8'h11, 8'h00,
                8'h17, 8'h02, 8'h00, 8'h00, 8'h13, 8'h02, 8'h82, 8'h18};
        rst_n = 1'b0; sel = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'd0, rdy_a}, 32'd0);
        check("rst_rx_ready_b", {31'd0, rdy_b}, 32'd0);
        check("rst_wr_valid", {31'd0, wv_a}, 32'd0);
        check("rst_wr_addr", wa_a, 32'd0);
        check("rst_entry", en_a, 32'd0);
        check("rst_flags", {28'd0, ev_a, dn_a, er_a, 1'b0}, 32'd0);
        check("rst_err_cnt", {24'd0, ec_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", {31'd0, rdy_a}, 32'd1);

        // Extended linear address 0x8010, then a 16-byte data record.
        send_str(":0200000480106A\n");
        check("ext_err", {31'd0, er_a}, 32'd0);
        check("ext_no_beats", q_a.size(), 32'd0);
        send_str(":10000000130101FF232411001702000013028218BC");
        check("first_valid", {31'd0, wv_a}, 32'd1);
        check("first_addr", wa_a, 32'h80100000);
        check("first_data", wd_a, 32'h13131313);
        check("first_strb", {28'd0, ws_a}, 32'h1);
        check("commit_rx_ready", {31'd0, rdy_a}, 32'd0);
        // Beats 0..2 complete on the next three edges, then stall beat 3.
        repeat (3) @(posedge clk);
        #1;
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", {31'd0, wv_a}, 32'd1);
            check("bp_addr", wa_a, 32'h80100000);
            check("bp_data", wd_a, 32'hFFFFFFFF);
            check("bp_strb", {28'd0, ws_a}, 32'h8);
            check("bp_rx_ready", {31'd0, rdy_a}, 32'd0);
            @(posedge clk);
            #1;
        end
        wr_ready = 1'b1;
        wait_idle();
        check("rec16_count", q_a.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop_beat("rec16", 32'h80100000 + (i & ~3), {4{rec[i]}}, 4'b0001 << (i % 4));
        end
        check("rec16_err", {31'd0, er_a}, 32'd0);

        // Offset wraps inside the 64 KiB segment; 0x9B zeroes the byte sum.
        send_str(":02FFFF00AABB9B");
        wait_idle();
        pop_beat("wrap0", 32'h8010FFFC, 32'hAAAAAAAA, 4'b1000);
        pop_beat("wrap1", 32'h80100000, 32'hBBBBBBBB, 4'b0001);
        check("wrap_err", {31'd0, er_a}, 32'd0);

        // Reset in the middle of COMMIT drops wr_valid at once.
        wr_ready = 1'b0;
        send_str(":0100000055AA");
        check("abort_pre_valid", {31'd0, wv_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, wv_a}, 32'd0);
        check("abort_rx_ready", {31'd0, rdy_a}, 32'd0);
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_no_beats", q_a.size(), 32'd0);

        // Bad checksum is rejected and leaves ext_hi at 0.
        send_str(":0200000480106B\n");
        check("badsum_err", {31'd0, er_a}, 32'd1);
        check("badsum_cnt", {24'd0, ec_a}, 32'd1);
        check("badsum_no_beats", q_a.size(), 32'd0);
        send_str(":0100000055AA");
        wait_idle();
        pop_beat("seg0", 32'h00000000, 32'h55555555, 4'b0001);

        // Entry point, then EOF; later characters are ignored.
        send_str(":040000058010000067\n");
        check("entry", en_a, 32'h80100000);
        check("entry_valid", {31'd0, ev_a}, 32'd1);
        send_str(":00000001F");
        check("done_before", {31'd0, dn_a}, 32'd0);
        send_char(8'h46);
        check("done_after", {31'd0, dn_a}, 32'd1);
        send_str(":0200000480106B\n:0100000055AA\n");
        check("done_ignore_cnt", {24'd0, ec_a}, 32'd1);
        check("done_rx_ready", {31'd0, rdy_a}, 32'd1);
        check("done_sticky", {31'd0, dn_a}, 32'd1);
        check("done_no_beats", q_a.size(), 32'd0);

        // Error recovery on the MAX_LEN=8 instance.
        sel = 1'b1;
        send_str(":10");
        check("rec_len_cnt", {24'd0, ec_b}, 32'd1);
        send_str(":1X...");
        check("rec_nonhex_cnt", {24'd0, ec_b}, 32'd2);
        send_str(":0000000:");
        check("rec_colon_cnt", {24'd0, ec_b}, 32'd3);
        send_str("010000007788\n");
        wait_idle();
        pop_beat("rec_ok", 32'h00000000, 32'h77777777, 4'b0001);
        check("rec_final_cnt", {24'd0, ec_b}, 32'd3);
        check("rec_err_flag", {31'd0, er_b}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
